axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
// Shares one AXI4 read port to external memory between NUM_REQ read masters (port 0 = I$ refill, port 1 = D$ refill).
// Round-robin grant; one outstanding burst at a time; grant held from AR accept to the final R beat.
// Sits between the fetch/load-store units and the core's external read bus. Write channels are not handled here.
// PARAMETERS
// NUM_REQ      2   number of requesting read masters (>=2)
// ADDR_WIDTH   32  AXI address width
// DATA_WIDTH   32  AXI read data width
// PORTS
// clk            in   1                  clock
// rst            in   1                  reset
// req_araddr     in   NUM_REQ*ADDR_WIDTH per-requester read address, slice i = requester i
// req_arlen      in   NUM_REQ*8          per-requester burst length (beats-1)
// req_arsize     in   NUM_REQ*3          per-requester beat size
// req_arburst    in   NUM_REQ*2          per-requester burst type
// req_arvalid    in   NUM_REQ            per-requester AR valid
// req_arready    out  NUM_REQ            per-requester AR accept
// req_rdata      out  DATA_WIDTH         read data, broadcast to all requesters
// req_rresp      out  2                  read response, broadcast
// req_rlast      out  1                  last beat, broadcast
// req_rvalid     out  NUM_REQ            R valid, only granted requester's bit set
// req_rready     in   NUM_REQ            per-requester R ready
// m_araddr       out  ADDR_WIDTH         memory-side AR address (registered)
// m_arlen        out  8                  memory-side burst length (registered)
// m_arsize       out  3                  memory-side beat size (registered)
// m_arburst      out  2                  memory-side burst type (registered)
// m_arvalid      out  1                  memory-side AR valid (registered)
// m_arready      in   1                  memory-side AR ready
// m_rdata        in   DATA_WIDTH         memory-side read data
// m_rresp        in   2                  memory-side read response
// m_rlast        in   1                  memory-side last beat
// m_rvalid       in   1                  memory-side R valid
// m_rready       out  1                  memory-side R ready
// protocol_err   out  1                  sticky: rlast beat count mismatched granted arlen
// BEHAVIOUR
// - Reset is synchronous, active-high. In reset: state=IDLE, m_arvalid=0, all m_ar* fields=0, protocol_err=0, rr_ptr=0, beat_ctr=0.
// - States and transitions:
//   - IDLE: winner = first requester with arvalid=1, searching from rr_ptr upward with wrap.
//     - Same cycle: req_arready[winner]=1 (combinational; all other bits 0). Latch winner's AR fields into m_ar*; grant_reg<=winner; beat_ctr<=0; m_arvalid<=1; go to ADDR.
//     - No arvalid: stay in IDLE.
//   - ADDR: hold m_ar* and m_arvalid stable. On m_arready=1: m_arvalid<=0, go to DATA. req_arready is all-zero.
//   - DATA:
//     - Datapath: req_rvalid[grant_reg]=m_rvalid; m_rready=req_rready[grant_reg]; rdata/rresp/rlast passed through combinationally.
//     - Per beat (m_rvalid && m_rready): beat_ctr++.
//     - On a beat with m_rlast: rr_ptr<=(grant_reg+1) mod NUM_REQ; go to IDLE.
// - Outside DATA: m_rready=0 and req_rvalid is all-zero, so stray R beats are back-pressured and never delivered.
// - Latency: a request presented in IDLE reaches m_arvalid on the next cycle. The first R beat is forwarded with zero added latency.
// - Arbitration fairness: after a burst from requester g completes, g has the lowest priority. With all requesters active, grants rotate strictly.
// - A new grant is taken only in IDLE, so at least one idle cycle separates consecutive bursts.
// - protocol_err is set (sticky until reset) when either:
//   - rlast arrives with beat_ctr != latched m_arlen; or
//   - a beat without rlast arrives with beat_ctr == m_arlen.
//   The FSM still returns to IDLE on rlast.
// - Reset mid-burst: immediately IDLE and all outputs at reset values. Draining of the in-flight memory burst is the responsibility of the memory side.
// - Requesters hold AR fields stable while arvalid=1 (AXI rule). The arbiter does not re-check them after acceptance.
// STRUCTURE
// - Package defines: axi_ar_t struct {addr, len, size, burst}; AXI_BURST_INCR = 2'b01; AXI_RESP_OKAY = 2'b00; arb_state_t enum {IDLE, ADDR, DATA}.
// - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt[N], binary gnt_idx, any_req. Purely combinational.
// - Top level holds the FSM, the AR register slice, rr_ptr, beat_ctr and the R-channel routing mux.
// TESTING
// 1 Single I$ miss: req0 araddr=0x0000_1040, arlen=3; m_arready after 2 cycles; 4 beats 0xA0..0xA3 with rlast on the 4th
//   -> req_arready[0] pulses once; m_araddr=0x1040; req_rvalid[0] on 4 beats, req_rvalid[1]=0 throughout; back in IDLE the cycle after rlast.
// 2 Simultaneous arvalid on both requesters from reset -> req0 granted first, req1 granted in the IDLE cycle after req0's rlast.
//   Repeat with both always requesting -> grants alternate 0,1,0,1.
// 3 Back-pressure: req_rready[1]=0 for 3 cycles mid-burst -> m_rready=0 for those cycles; data is not lost; beat_ctr stalls.
// 4 Stray R: assert m_rvalid in IDLE and in ADDR -> m_rready=0, no req_rvalid bit set, state unchanged.
// 5 Length mismatch: arlen=3, rlast on beat 2 -> protocol_err=1 and stays 1 across later good bursts; FSM returns to IDLE.
// 6 Reset asserted during DATA beat 1 -> next cycle: m_arvalid=0, m_rready=0, protocol_err=0; a subsequent req1 request is granted (rr_ptr=0, req0 idle).

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter_pkg
//  Description : Shared types and constants for the AXI4 read-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_read_arbiter_pkg;

    // Width of the address field carried in the AR record; the arbiter's
    // ADDR_WIDTH parameter must not exceed it.
    localparam int AXI_ADDR_W = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // One AR-channel request
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ar_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage : axi_read_arbiter_pkg
`default_nettype wire

// File: rtl/axi_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches upward from the
//                priority pointer with wrap; returns one-hot and binary grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any_req
);

    logic             w_found;
    logic [IDX_W-1:0] w_j;

    // First asserted request at or after the pointer wins
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_gnt[w_j]   = 1'b1;
                o_gnt_idx    = w_j;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Shares one AXI4 read port among NUM_REQ masters. Round-robin
//                grant, one burst outstanding, grant held from AR accept to
//                the final R beat. Sticky protocol_err on beat-count mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]          req_arlen,
    input  logic [NUM_REQ*3-1:0]          req_arsize,
    input  logic [NUM_REQ*2-1:0]          req_arburst,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                    req_rresp,
    output logic                          req_rlast,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          protocol_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       r_state, w_state_nxt;
    axi_ar_t          r_ar, w_win_ar;
    logic             r_arvalid;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [7:0]       r_beat_ctr;
    logic             r_perr;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any_req;
    logic               w_beat;
    logic               w_len_err;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req     (req_arvalid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any_req (w_any_req)
    );

    // Select the winning requester's AR fields (one-hot OR mux)
    always_comb begin
        w_win_ar = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_ar.addr  = AXI_ADDR_W'(req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
                w_win_ar.len   = req_arlen[i*8 +: 8];
                w_win_ar.size  = req_arsize[i*3 +: 3];
                w_win_ar.burst = req_arburst[i*2 +: 2];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state plus AR accept and R routing; R is blocked outside DATA
    always_comb begin
        w_state_nxt = r_state;
        req_arready = '0;
        req_rvalid  = '0;
        m_rready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_arready = w_gnt;
                if (w_any_req) w_state_nxt = ADDR;
            end
            ADDR: begin
                if (m_arready) w_state_nxt = DATA;
            end
            DATA: begin
                req_rvalid[r_grant] = m_rvalid;
                m_rready            = req_rready[r_grant];
                if (m_rvalid && req_rready[r_grant] && m_rlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_beat    = (r_state == DATA) && m_rvalid && m_rready;
    // Error if rlast comes early/late, or a non-last beat lands on the final count
    assign w_len_err = m_rlast ? (r_beat_ctr != r_ar.len) : (r_beat_ctr == r_ar.len);

    // AR register slice, grant bookkeeping, beat counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar       <= '0;
            r_arvalid  <= 1'b0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_ctr <= '0;
            r_perr     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_ar       <= w_win_ar;
                r_grant    <= w_gnt_idx;
                r_beat_ctr <= '0;
                r_arvalid  <= 1'b1;
            end
            if (r_state == ADDR && m_arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_beat) begin
                r_beat_ctr <= r_beat_ctr + 8'd1;
                if (w_len_err) r_perr <= 1'b1;
                // Just-served requester drops to lowest priority
                if (m_rlast) begin
                    r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ-1)) ? '0 : r_grant + IDX_W'(1);
                end
            end
        end
    end

    assign m_araddr     = ADDR_WIDTH'(r_ar.addr);
    assign m_arlen      = r_ar.len;
    assign m_arsize     = r_ar.size;
    assign m_arburst    = r_ar.burst;
    assign m_arvalid    = r_arvalid;
    assign req_rdata    = m_rdata;
    assign req_rresp    = m_rresp;
    assign req_rlast    = m_rlast;
    assign protocol_err = r_perr;

endmodule : axi_read_arbiter
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_arbiter
//  Description : Directed bench for axi_read_arbiter with grant and R-beat
//                scoreboards fed by the stimulus and drained by monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] req_araddr  = '0;
    logic [N*8-1:0]  req_arlen   = '0;
    logic [N*3-1:0]  req_arsize  = '0;
    logic [N*2-1:0]  req_arburst = '0;
    logic [N-1:0]    req_arvalid = '0;
    logic [N-1:0]    req_arready;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_rresp;
    logic            req_rlast;
    logic [N-1:0]    req_rvalid;
    logic [N-1:0]    req_rready  = '1;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arvalid;
    logic            m_arready   = 1'b0;
    logic [DW-1:0]   m_rdata     = '0;
    logic [1:0]      m_rresp     = AXI_RESP_OKAY;
    logic            m_rlast     = 1'b0;
    logic            m_rvalid    = 1'b0;
    logic            m_rready;
    logic            protocol_err;

    always #5 clk = ~clk;

    axi_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
        .req_arburst(req_arburst), .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .protocol_err(protocol_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
    } rexp_t;

    rexp_t rq[$];   // expected R beats in delivery order
    int    gq[$];   // expected grant order

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (!rst && (|req_arready)) begin
            int gi;
            gi = (req_arready == 2'b01) ? 0 : (req_arready == 2'b10) ? 1 : -1;
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got req_arready=%b expected none", req_arready);
            end else begin
                int e;
                e = gq.pop_front();
                chk("grant_port", 64'(gi), 64'(e));
            end
        end
    end

    // R monitor: a beat is delivered when a requester's valid and ready meet
    always @(negedge clk) begin
        if (!rst && (|(req_rvalid & req_rready))) begin
            int rp;
            rp = (req_rvalid == 2'b01) ? 0 : (req_rvalid == 2'b10) ? 1 : -1;
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rbeat_unexpected: got req_rvalid=%b data=0x%0h expected none", req_rvalid, req_rdata);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rbeat_port", 64'(rp), 64'(e.port));
                chk("rbeat_data", 64'(req_rdata), 64'(e.data));
                chk("rbeat_last", 64'(req_rlast), 64'(e.last));
                chk("rbeat_resp", 64'(req_rresp), 64'(AXI_RESP_OKAY));
            end
        end
    end

    // Requester p presents an AR and holds it until accepted
    task automatic do_req(input int p, input logic [31:0] addr, input logic [7:0] len);
        int   t;
        logic g;
        req_araddr[p*AW +: AW]  = addr;
        req_arlen[p*8 +: 8]     = len;
        req_arsize[p*3 +: 3]    = 3'd2;
        req_arburst[p*2 +: 2]   = AXI_BURST_INCR;
        req_arvalid[p]          = 1'b1;
        t = 0;
        g = 1'b0;
        while (!g && t < 200) begin
            @(negedge clk);
            g = req_arready[p];
            t++;
        end
        @(posedge clk);
        #1 req_arvalid[p] = 1'b0;
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL arready_timeout: got no accept for port %0d expected accept", p);
        end
    endtask

    // Memory AR side: wait for m_arvalid, check fields, accept after dly cycles
    task automatic mem_ar(input logic [31:0] ea, input logic [7:0] el, input int dly);
        int t;
        t = 0;
        @(negedge clk);
        while (!m_arvalid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("m_arvalid_seen", 64'(m_arvalid), 64'd1);
        chk("m_araddr", 64'(m_araddr), 64'(ea));
        chk("m_arlen", 64'(m_arlen), 64'(el));
        chk("m_arsize", 64'(m_arsize), 64'd2);
        chk("m_arburst", 64'(m_arburst), 64'(AXI_BURST_INCR));
        repeat (dly + 1) @(posedge clk);
        #1 m_arready = 1'b1;
        @(posedge clk);
        #1 m_arready = 1'b0;
    endtask

    // Memory R side: nbeats beats, rlast on beat rlast_beat, optional 3-cycle stall
    task automatic mem_beats(input int port, input int nbeats, input int rlast_beat,
                             input logic [31:0] d0, input int stall_beat);
        int   t;
        logic r;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = d0 + 32'(b);
            m_rlast  = (b == rlast_beat);
            rq.push_back('{port: port, data: d0 + 32'(b), last: (b == rlast_beat)});
            if (b == stall_beat) begin
                req_rready[port] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_m_rready", 64'(m_rready), 64'd0);
                    chk("stall_rvalid_held", 64'(req_rvalid[port]), 64'd1);
                    @(posedge clk);
                end
                #1 req_rready[port] = 1'b1;
            end
            t = 0;
            r = 1'b0;
            while (!r && t < 200) begin
                @(negedge clk);
                r = m_rready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!r) begin
                checks++;
                errors++;
                $display("FAIL rready_timeout: got m_rready=0 on beat %0d expected 1", b);
            end
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic mem_burst(input int port, input logic [31:0] ea, input logic [7:0] el,
                             input int nbeats, input int rlast_beat, input logic [31:0] d0,
                             input int dly, input int stall_beat);
        mem_ar(ea, el, dly);
        mem_beats(port, nbeats, rlast_beat, d0, stall_beat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        chk("rst_m_arlen", 64'(m_arlen), 64'd0);
        chk("rst_protocol_err", 64'(protocol_err), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_req_rvalid", 64'(req_rvalid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single I$ miss, 4 beats
        gq.push_back(0);
        do_req(0, 32'h0000_1040, 8'd3);
        chk("t1_arvalid_next_cycle", 64'(m_arvalid), 64'd1);
        mem_burst(0, 32'h0000_1040, 8'd3, 4, 3, 32'hA0, 2, -1);
        @(negedge clk);
        chk("t1_idle_m_rready", 64'(m_rready), 64'd0);
        chk("t1_idle_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("t1_protocol_err", 64'(protocol_err), 64'd0);
        @(posedge clk);
        #1;

        // 2a: simultaneous requests from reset
        do_reset();
        gq.push_back(0);
        gq.push_back(1);
        fork
            do_req(0, 32'h0000_2000, 8'd1);
            do_req(1, 32'h0000_3000, 8'd1);
            begin
                mem_burst(0, 32'h0000_2000, 8'd1, 2, 1, 32'hB0, 0, -1);
                @(negedge clk);
                chk("t2_req1_next_idle", 64'(req_arready), 64'b10);
                mem_burst(1, 32'h0000_3000, 8'd1, 2, 1, 32'hC0, 0, -1);
            end
        join

        // 2b: both always requesting, single-beat bursts -> 0,1,0,1
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        fork
            begin do_req(0, 32'h0000_4000, 8'd0); do_req(0, 32'h0000_4100, 8'd0); end
            begin do_req(1, 32'h0000_5000, 8'd0); do_req(1, 32'h0000_5100, 8'd0); end
            begin
                mem_burst(0, 32'h0000_4000, 8'd0, 1, 0, 32'hD0, 0, -1);
                mem_burst(1, 32'h0000_5000, 8'd0, 1, 0, 32'hD1, 0, -1);
                mem_burst(0, 32'h0000_4100, 8'd0, 1, 0, 32'hD2, 0, -1);
                mem_burst(1, 32'h0000_5100, 8'd0, 1, 0, 32'hD3, 0, -1);
            end
        join
        @(negedge clk);
        chk("t2_protocol_err", 64'(protocol_err), 64'd0);
        @(posedge clk);
        #1;

        // 3: requester 1 back-pressures for 3 cycles on beat 2
        gq.push_back(1);
        do_req(1, 32'h0000_6000, 8'd3);
        mem_burst(1, 32'h0000_6000, 8'd3, 4, 3, 32'hE0, 1, 2);
        @(negedge clk);
        chk("t3_protocol_err", 64'(protocol_err), 64'd0);
        @(posedge clk);
        #1;

        // 4: stray R beats in IDLE and ADDR
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD;
        @(negedge clk);
        chk("t4_idle_m_rready", 64'(m_rready), 64'd0);
        chk("t4_idle_rvalid", 64'(req_rvalid), 64'd0);
        @(posedge clk);
        #1;
        gq.push_back(0);
        do_req(0, 32'h0000_7000, 8'd2);
        @(negedge clk);
        chk("t4_addr_m_rready", 64'(m_rready), 64'd0);
        chk("t4_addr_rvalid", 64'(req_rvalid), 64'd0);
        chk("t4_addr_arvalid", 64'(m_arvalid), 64'd1);
        @(posedge clk);
        #1 m_rvalid = 1'b0;
        mem_burst(0, 32'h0000_7000, 8'd2, 3, 2, 32'hF0, 0, -1);

        // 5: rlast on beat 2 of a 4-beat burst
        gq.push_back(0);
        do_req(0, 32'h0000_8000, 8'd3);
        mem_burst(0, 32'h0000_8000, 8'd3, 2, 1, 32'h10, 0, -1);
        @(negedge clk);
        chk("t5_protocol_err_set", 64'(protocol_err), 64'd1);
        chk("t5_idle_m_rready", 64'(m_rready), 64'd0);
        @(posedge clk);
        #1;
        gq.push_back(1);
        do_req(1, 32'h0000_8100, 8'd1);
        mem_burst(1, 32'h0000_8100, 8'd1, 2, 1, 32'h20, 0, -1);
        @(negedge clk);
        chk("t5_protocol_err_sticky", 64'(protocol_err), 64'd1);
        @(posedge clk);
        #1;

        // 6: reset during the first DATA beat
        gq.push_back(0);
        do_req(0, 32'h0000_9000, 8'd3);
        mem_ar(32'h0000_9000, 8'd3, 0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h99;
        m_rlast  = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("t6_rst_m_rready", 64'(m_rready), 64'd0);
        chk("t6_rst_protocol_err", 64'(protocol_err), 64'd0);
        chk("t6_rst_rvalid", 64'(req_rvalid), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_rvalid = 1'b0;
        gq.push_back(1);
        do_req(1, 32'h0000_A000, 8'd1);
        mem_burst(1, 32'h0000_A000, 8'd1, 2, 1, 32'h30, 0, -1);

        @(negedge clk);
        chk("end_rbeats_drained", 64'(rq.size()), 64'd0);
        chk("end_grants_drained", 64'(gq.size()), 64'd0);
        chk("end_protocol_err", 64'(protocol_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_read_arbiter
`default_nettype wire
